// File: rtl/cpu7_ifu_ibuf_pkg.sv
// rtl/cpu7_ifu_ibuf_pkg.sv - shared types and constants for the IFU instruction buffer
package cpu7_ifu_ibuf_pkg;

  // Default buffer depth in instructions.
  localparam int IBUF_DEPTH = 4;

  // Byte distance between the two instructions of a fetch packet.
  localparam logic [31:0] IBUF_INST_STEP = 32'd4;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_entry_t;

  // A packet whose first wanted instruction is the upper word carries only one instruction.
  function automatic logic [1:0] ibuf_npush(input logic pc_upper_word);
    return pc_upper_word ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/cpu7_ifu_ibuf_if.sv
// rtl/cpu7_ifu_ibuf_if.sv - fetch-return and decode-side signals of the instruction buffer
interface cpu7_ifu_ibuf_if;

  // Fetch packet from the icache return stage.
  logic [63:0] icu_ifu_data_ic2;
  logic        icu_ifu_data_valid_ic2;
  logic [31:0] fdp_ibuf_pc_ic2;
  logic        ibuf_fdp_ready;

  // Decode-side head of the buffer.
  logic        exu_ifu_stall_req;
  logic        ibuf_dec_vld_d;
  logic [31:0] ibuf_dec_inst_d;
  logic [31:0] ibuf_dec_pc_d;

  // Fetch/decode environment around the buffer.
  modport master (
    output icu_ifu_data_ic2, icu_ifu_data_valid_ic2, fdp_ibuf_pc_ic2, exu_ifu_stall_req,
    input  ibuf_fdp_ready, ibuf_dec_vld_d, ibuf_dec_inst_d, ibuf_dec_pc_d
  );

  // The buffer itself.
  modport slave (
    input  icu_ifu_data_ic2, icu_ifu_data_valid_ic2, fdp_ibuf_pc_ic2, exu_ifu_stall_req,
    output ibuf_fdp_ready, ibuf_dec_vld_d, ibuf_dec_inst_d, ibuf_dec_pc_d
  );

endinterface

// File: rtl/cpu7_ifu_ibuf.sv
// rtl/cpu7_ifu_ibuf.sv - instruction fetch buffer between icache return and decode
module cpu7_ifu_ibuf
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  cpu7_ifu_ibuf_if.slave    ibus,
  input  logic              ibuf_flush,
  output logic [PTR_W:0]    ibuf_count
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  ibuf_entry_t mem [DEPTH];

  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  ptr_t        wr_ptr_p1;
  cnt_t        count;
  cnt_t        count_next;
  ptr_t        wr_ptr_next;
  ptr_t        rd_ptr_next;
  logic        ready;
  logic        push;
  logic        pop;
  logic        vld;
  logic [1:0]  npush;
  ibuf_entry_t head;

  // Room for a full two-instruction packet, judged on the registered count only.
  assign ready     = (count <= cnt_t'(DEPTH - 2));
  assign vld       = (count != '0);
  assign push      = ibus.icu_ifu_data_valid_ic2 & ready & ~ibuf_flush;
  assign pop       = vld & ~ibus.exu_ifu_stall_req & ~ibuf_flush;
  assign wr_ptr_p1 = wr_ptr + ptr_t'(1);
  assign head      = mem[rd_ptr];

  // Next occupancy and pointer values for a non-flush cycle.
  always_comb begin
    npush       = 2'd0;
    count_next  = count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (push) begin
      npush = ibuf_npush(ibus.fdp_ibuf_pc_ic2[2]);
    end
    count_next  = count + cnt_t'(npush) - cnt_t'(pop);
    wr_ptr_next = wr_ptr + ptr_t'(npush);
    rd_ptr_next = rd_ptr + ptr_t'(pop);
  end

  // Pointer and count registers; a redirect empties the buffer and realigns pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ibuf_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Entry storage: an aligned packet fills two slots, an upper-word packet fills one.
  always_ff @(posedge clk) begin
    if (push) begin
      if (!ibus.fdp_ibuf_pc_ic2[2]) begin
        mem[wr_ptr]    <= '{pc: ibus.fdp_ibuf_pc_ic2, inst: ibus.icu_ifu_data_ic2[31:0]};
        mem[wr_ptr_p1] <= '{pc: ibus.fdp_ibuf_pc_ic2 + IBUF_INST_STEP,
                            inst: ibus.icu_ifu_data_ic2[63:32]};
      end else begin
        mem[wr_ptr]    <= '{pc: ibus.fdp_ibuf_pc_ic2, inst: ibus.icu_ifu_data_ic2[63:32]};
      end
    end
  end

  // Decode outputs are zeroed while the buffer is empty so stale slots never leak out.
  always_comb begin
    ibus.ibuf_fdp_ready  = ready;
    ibus.ibuf_dec_vld_d  = vld;
    ibus.ibuf_dec_inst_d = vld ? head.inst : 32'd0;
    ibus.ibuf_dec_pc_d   = vld ? head.pc   : 32'd0;
    ibuf_count           = count;
  end

  // Fetch must not present a packet while the buffer reports no room (redirect cycles excepted).
  ap_no_valid_without_ready : assert property (
    @(posedge clk) disable iff (reset)
    !(ibus.icu_ifu_data_valid_ic2 && !ready && !ibuf_flush)
  );

  // Occupancy can never exceed the buffer depth.
  ap_count_bound : assert property (
    @(posedge clk) disable iff (reset)
    count <= cnt_t'(DEPTH)
  );

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// tb/tb_cpu7_ifu_ibuf.sv - scoreboard bench for the IFU instruction buffer
module tb_cpu7_ifu_ibuf;
  import cpu7_ifu_ibuf_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ibuf_flush = 1'b0;
  logic [2:0] ibuf_count;

  int checks = 0;
  int errors = 0;
  ibuf_entry_t sb[$];

  cpu7_ifu_ibuf_if ibus ();

  cpu7_ifu_ibuf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ibus       (ibus),
    .ibuf_flush (ibuf_flush),
    .ibuf_count (ibuf_count)
  );

  always #5 clk = ~clk;

  // Comparison helper shared by the stimulus and the monitor.
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one packet once the buffer has room and record the entries it should produce.
  task automatic send(input logic [31:0] pc, input logic [63:0] data);
    int n;
    n = 0;
    while (!ibus.ibuf_fdp_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!ibus.ibuf_fdp_ready) begin
      chk("send_ready_timeout", 64'd0, 64'd1);
      return;
    end
    ibus.icu_ifu_data_valid_ic2 = 1'b1;
    ibus.fdp_ibuf_pc_ic2        = pc;
    ibus.icu_ifu_data_ic2       = data;
    if (!pc[2]) begin
      sb.push_back('{pc: pc, inst: data[31:0]});
      sb.push_back('{pc: pc + 32'd4, inst: data[63:32]});
    end else begin
      sb.push_back('{pc: pc, inst: data[63:32]});
    end
    cyc();
    ibus.icu_ifu_data_valid_ic2 = 1'b0;
  endtask

  // Release stall and let the buffer empty, bounded in cycles.
  task automatic drain(input string tag);
    int n;
    ibus.exu_ifu_stall_req = 1'b0;
    n = 0;
    while ((sb.size() != 0 || ibuf_count != 3'd0) && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_drain_sb"}, 64'(sb.size()), 64'd0);
    chk({tag, "_drain_count"}, 64'(ibuf_count), 64'd0);
    chk({tag, "_drain_vld"}, 64'(ibus.ibuf_dec_vld_d), 64'd0);
  endtask

  // Monitor: compare the presented head with the oldest expected entry; retire it on a pop.
  always @(negedge clk) begin
    if (!reset) begin
      if (ibus.ibuf_dec_vld_d) begin
        if (sb.size() == 0) begin
          chk("head_unexpected", 64'd1, 64'd0);
        end else begin
          chk("head_pc", 64'(ibus.ibuf_dec_pc_d), 64'(sb[0].pc));
          chk("head_inst", 64'(ibus.ibuf_dec_inst_d), 64'(sb[0].inst));
          if (!ibus.exu_ifu_stall_req && !ibuf_flush) void'(sb.pop_front());
        end
      end else begin
        chk("empty_pc_zero", 64'(ibus.ibuf_dec_pc_d), 64'd0);
        chk("empty_inst_zero", 64'(ibus.ibuf_dec_inst_d), 64'd0);
      end
      if (ibuf_flush) sb.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] D1 = 64'h02800c21_02800421;

  initial begin
    ibus.icu_ifu_data_ic2       = '0;
    ibus.icu_ifu_data_valid_ic2 = 1'b0;
    ibus.fdp_ibuf_pc_ic2        = '0;
    ibus.exu_ifu_stall_req      = 1'b0;

    // Reset state
    #2;
    chk("rst_vld", 64'(ibus.ibuf_dec_vld_d), 64'd0);
    chk("rst_ready", 64'(ibus.ibuf_fdp_ready), 64'd1);
    chk("rst_count", 64'(ibuf_count), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // 1. Aligned push, no stall
    send(32'h1c000000, D1);
    chk("t1_vld", 64'(ibus.ibuf_dec_vld_d), 64'd1);
    chk("t1_inst0", 64'(ibus.ibuf_dec_inst_d), 64'h02800421);
    chk("t1_pc0", 64'(ibus.ibuf_dec_pc_d), 64'h1c000000);
    cyc();
    chk("t1_inst1", 64'(ibus.ibuf_dec_inst_d), 64'h02800c21);
    chk("t1_pc1", 64'(ibus.ibuf_dec_pc_d), 64'h1c000004);
    cyc();
    chk("t1_vld_off", 64'(ibus.ibuf_dec_vld_d), 64'd0);
    drain("t1");

    // 2. Unaligned push: one entry only
    ibus.exu_ifu_stall_req = 1'b1;
    send(32'h1c000004, D1);
    chk("t2_count", 64'(ibuf_count), 64'd1);
    chk("t2_inst", 64'(ibus.ibuf_dec_inst_d), 64'h02800c21);
    chk("t2_pc", 64'(ibus.ibuf_dec_pc_d), 64'h1c000004);
    drain("t2");

    // 3. Backpressure: fill under stall, then release and watch ready return
    ibus.exu_ifu_stall_req = 1'b1;
    send(32'h1c000010, 64'h11111111_22222222);
    chk("t3_count_half", 64'(ibuf_count), 64'd2);
    chk("t3_ready_half", 64'(ibus.ibuf_fdp_ready), 64'd1);
    send(32'h1c000018, 64'h33333333_44444444);
    chk("t3_count_full", 64'(ibuf_count), 64'd4);
    chk("t3_ready_full", 64'(ibus.ibuf_fdp_ready), 64'd0);
    cyc();
    cyc();
    chk("t3_count_hold", 64'(ibuf_count), 64'd4);
    chk("t3_ready_hold", 64'(ibus.ibuf_fdp_ready), 64'd0);
    ibus.exu_ifu_stall_req = 1'b0;
    begin
      logic [2:0] exp_cnt [5];
      logic       exp_rdy [5];
      exp_cnt = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t3_rel_count%0d", i), 64'(ibuf_count), 64'(exp_cnt[i]));
        chk($sformatf("t3_rel_ready%0d", i), 64'(ibus.ibuf_fdp_ready), 64'(exp_rdy[i]));
        cyc();
      end
    end
    drain("t3");

    // 4. Flush collides with push and pop at count = 3
    ibus.exu_ifu_stall_req = 1'b1;
    send(32'h1c000040, 64'h55555555_66666666);
    send(32'h1c000054, 64'h77777777_88888888);
    chk("t4_count3", 64'(ibuf_count), 64'd3);
    ibus.exu_ifu_stall_req      = 1'b0;
    ibuf_flush                  = 1'b1;
    ibus.icu_ifu_data_valid_ic2 = 1'b1;
    ibus.fdp_ibuf_pc_ic2        = 32'h1c000060;
    ibus.icu_ifu_data_ic2       = 64'h99999999_aaaaaaaa;
    cyc();
    ibuf_flush                  = 1'b0;
    ibus.icu_ifu_data_valid_ic2 = 1'b0;
    chk("t4_count0", 64'(ibuf_count), 64'd0);
    chk("t4_vld0", 64'(ibus.ibuf_dec_vld_d), 64'd0);
    chk("t4_inst0", 64'(ibus.ibuf_dec_inst_d), 64'd0);
    chk("t4_ready1", 64'(ibus.ibuf_fdp_ready), 64'd1);
    ibus.exu_ifu_stall_req = 1'b1;
    send(32'h1c000100, 64'hbbbbbbbb_cccccccc);
    chk("t4_new_pc", 64'(ibus.ibuf_dec_pc_d), 64'h1c000100);
    chk("t4_new_inst", 64'(ibus.ibuf_dec_inst_d), 64'hcccccccc);
    chk("t4_new_count", 64'(ibuf_count), 64'd2);
    drain("t4");

    // 5. Wrap-around with alternating packet alignment and random stalls
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(32'h1c001000 + 32'(i) * 32'd16 + ((i % 2) != 0 ? 32'd4 : 32'd0),
               {32'h0a000001 + 32'(i) * 32'd2, 32'h0a000000 + 32'(i) * 32'd2});
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          ibus.exu_ifu_stall_req = 1'($urandom_range(0, 1));
          cyc();
        end
      end
    join
    drain("t5");

    // 6. Asynchronous reset mid-stream with two entries held
    ibus.exu_ifu_stall_req = 1'b1;
    send(32'h1c000200, 64'hdddddddd_eeeeeeee);
    chk("t6_count2", 64'(ibuf_count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_vld", 64'(ibus.ibuf_dec_vld_d), 64'd0);
    chk("t6_inst", 64'(ibus.ibuf_dec_inst_d), 64'd0);
    chk("t6_pc", 64'(ibus.ibuf_dec_pc_d), 64'd0);
    chk("t6_ready", 64'(ibus.ibuf_fdp_ready), 64'd1);
    chk("t6_count", 64'(ibuf_count), 64'd0);
    sb.delete();
    cyc();
    reset = 1'b0;
    cyc();
    chk("t6_post_count", 64'(ibuf_count), 64'd0);
    send(32'h1c000304, 64'h12345678_9abcdef0);
    chk("t6_resume_count", 64'(ibuf_count), 64'd1);
    chk("t6_resume_pc", 64'(ibus.ibuf_dec_pc_d), 64'h1c000304);
    chk("t6_resume_inst", 64'(ibus.ibuf_dec_inst_d), 64'h12345678);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_ibuf.md
Name: cpu7_ifu_ibuf

Overview:
Instruction fetch buffer between the icache return path (ic2) and the decode stage inside the IFU. Accepts 64-bit fetch packets of up to two 32-bit instructions each. Queues them with their PCs and presents one instruction per cycle to decode. Decouples icache latency from decode/EXU stalls and is cleared on every redirect (branch, exception, ertn).

Parameters:
- DEPTH, 4, instruction entries; power of 2, >= 2.
- PTR_W, 2, log2(DEPTH); entry count is PTR_W+1 bits wide.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- icu_ifu_data_ic2  in  64  fetch packet; [31:0] = inst at 8-byte-aligned addr, [63:32] = inst at addr+4
- icu_ifu_data_valid_ic2  in  1  packet valid this cycle
- fdp_ibuf_pc_ic2  in  32  PC of first wanted inst in packet
- ibuf_fdp_ready  out  1  buffer can accept a full packet next push
- ibuf_flush  in  1  redirect (br_taken | except | ertn_e); clears buffer
- exu_ifu_stall_req  in  1  decode/EXU stall; head must not retire
- ibuf_dec_vld_d  out  1  head entry valid
- ibuf_dec_inst_d  out  32  head instruction
- ibuf_dec_pc_d  out  32  head PC
- ibuf_count  out  PTR_W+1  occupied entries (debug/perf)

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, ibuf_dec_vld_d = 0, ibuf_dec_inst_d = 0, ibuf_dec_pc_d = 0, ibuf_fdp_ready = 1.
  - Entry storage need not be reset.
- Push: push = icu_ifu_data_valid_ic2 & ibuf_fdp_ready & ~ibuf_flush.
  - If fdp_ibuf_pc_ic2[2] = 0: push two entries, in order {data[31:0], pc} then {data[63:32], pc+4}.
  - If fdp_ibuf_pc_ic2[2] = 1: push one entry, {data[63:32], pc}.
  - pc[1:0] is ignored and stored as received.
- Pop: pop = ibuf_dec_vld_d & ~exu_ifu_stall_req & ~ibuf_flush; advances rd_ptr by 1.
- Count update: count_next = count + npush - pop.
  - Pointers wrap modulo DEPTH; storage is written at wr_ptr and wr_ptr+1 (mod DEPTH).
- Ready: ibuf_fdp_ready = (DEPTH - count) >= 2, computed from the registered count.
  - The same-cycle pop is not credited (conservative, no comb path from stall).
- Valid without ready: icu_ifu_data_valid_ic2 with ibuf_fdp_ready = 0 is a protocol violation by fdp. The packet is dropped, nothing changes, and a simulation assertion fires.
- Latency: a packet pushed in cycle N is visible at the head in cycle N+1 when the buffer was empty. There is no same-cycle bypass.
- Output: ibuf_dec_vld_d = (count != 0).
  - inst/pc are the head entry when valid and forced to 0 when empty.
- Flush priority: flush beats push and pop in the same cycle.
  - Next cycle: count = 0, wr_ptr = rd_ptr = 0, vld = 0.
  - A packet arriving in the flush cycle is discarded.
  - The cycle after flush accepts new-target packets normally.
- Stall while empty: no effect.
- Stall while full: count holds and ready stays 0.
- Simultaneous push(2) and pop at count = DEPTH-2: legal. Result count = DEPTH-1, and ready drops to 0 next cycle.
- Full/empty: never over- or under-flows given the ready rule. An assertion checks count <= DEPTH.
- Reset asserted mid-operation: immediate clear per the reset values; no partial packet is retained.

Decomposition:
- IBUF_DEPTH default and the flush-source OR (br_taken | except | ertn_e) go in defines.vh as shared macros. The parent IFU builds ibuf_flush from the same expression fdp uses.
- No sub-module: storage is an inline DEPTH x 64 register array ({pc, inst}) with two write ports and one read port.
- Pointer/count logic stays in the module.

Test Plan:
1. Aligned push: pc = 0x1c000000, data = 0x02800c21_02800421, valid, no stall.
   -> Next cycle: vld = 1, inst = 0x02800421, pc = 0x1c000000.
   -> Following cycle: inst = 0x02800c21, pc = 0x1c000004.
   -> Then vld = 0.
2. Unaligned push: pc = 0x1c000004, same data.
   -> One entry only: inst = 0x02800c21, pc = 0x1c000004; count = 1.
3. Backpressure: stall held, push two aligned packets.
   -> count = 4, ready = 0.
   -> Release stall: four pops in order, and ready returns to 1 once count <= 2.
4. Flush collision: count = 3, with push, pop and flush all in the same cycle.
   -> Next cycle count = 0, vld = 0, inst = 0.
   -> Next packet pc = 0x1c000100 appears at the head with that PC.
5. Wrap-around: 10 alternating aligned/unaligned packets with random single-cycle stalls.
   -> Output PC sequence matches a reference queue exactly; no lost or duplicated entries across pointer wrap.
6. Async reset pulsed mid-stream with count = 2.
   -> Outputs go to 0 and ready to 1 without waiting for a clock edge; operation resumes cleanly after deassertion.
